// File: rtl/ball_coll_pkg.sv
// Shared types and helpers for the ball pair collision sweeper.
package ball_coll_pkg;

  localparam int RES_W_DEF = 32;
  localparam int IDX_W_MAX = 4;

  typedef logic signed [RES_W_DEF-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sweep_state_t;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] i;
    logic [IDX_W_MAX-1:0] j;
    logic [RES_W_DEF-1:0] sq_dist;
    logic [RES_W_DEF-1:0] nxt_sq_dist;
    res_t                 inter_x;
    res_t                 inter_y;
    logic                 hit;
  } ball_pair_res_t;

  // Number of unordered pairs among n balls.
  function automatic int pair_cnt(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Width of a ball index.
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ball_pair_calc_pipe.sv
// Three-stage shared arithmetic pipe: differences, squares/inner product,
// projection terms and hit flag. Every stage advances only when en is high,
// and a valid tag travels with each slot so bubbles never surface.
module ball_pair_calc_pipe #(
  parameter int          COORD_W  = 16,
  parameter int          RES_W    = 32,
  parameter int          IDX_W    = 2,
  parameter int          IP_SHIFT = 2,
  parameter int unsigned DIAM_SQ  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      inValid,
  input  logic [IDX_W-1:0]          inI,
  input  logic [IDX_W-1:0]          inJ,
  input  logic signed [COORD_W-1:0] xi,
  input  logic signed [COORD_W-1:0] xj,
  input  logic signed [COORD_W-1:0] yi,
  input  logic signed [COORD_W-1:0] yj,
  input  logic signed [COORD_W-1:0] vxi,
  input  logic signed [COORD_W-1:0] vxj,
  input  logic signed [COORD_W-1:0] vyi,
  input  logic signed [COORD_W-1:0] vyj,
  output logic                      pipeBusy,
  output logic                      outValid,
  output logic [IDX_W-1:0]          outI,
  output logic [IDX_W-1:0]          outJ,
  output logic [RES_W-1:0]          sqDist,
  output logic [RES_W-1:0]          nxtSqDist,
  output logic signed [RES_W-1:0]   interX,
  output logic signed [RES_W-1:0]   interY,
  output logic                      hit
);

  logic signed [RES_W-1:0] dxC, dyC, dvxC, dvyC;
  logic signed [RES_W-1:0] s1Dx, s1Dy, s1Dvx, s1Dvy;
  logic                    s1Valid;
  logic [IDX_W-1:0]        s1I, s1J;

  logic signed [RES_W-1:0] nxX, nxY, ipSum, ipC;
  logic [RES_W-1:0]        sqC, nxtC;
  logic signed [RES_W-1:0] s2Dx, s2Dy, s2Ip;
  logic [RES_W-1:0]        s2Sq, s2Nxt;
  logic                    s2Valid;
  logic [IDX_W-1:0]        s2I, s2J;

  logic signed [RES_W-1:0] interXC, interYC;
  logic                    hitC;

  // Sign-extend every operand to the result width before subtracting.
  always_comb begin
    dxC  = RES_W'(xi) - RES_W'(xj);
    dyC  = RES_W'(yi) - RES_W'(yj);
    dvxC = RES_W'(vxi) - RES_W'(vxj);
    dvyC = RES_W'(vyi) - RES_W'(vyj);
  end

  // Stage 1 captures the pair differences.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1I     <= '0;
      s1J     <= '0;
      s1Dx    <= '0;
      s1Dy    <= '0;
      s1Dvx   <= '0;
      s1Dvy   <= '0;
    end else if (en) begin
      s1Valid <= inValid;
      s1I     <= inI;
      s1J     <= inJ;
      s1Dx    <= dxC;
      s1Dy    <= dyC;
      s1Dvx   <= dvxC;
      s1Dvy   <= dvyC;
    end
  end

  // Squared distances now and one frame ahead, plus the scaled inner product.
  always_comb begin
    nxX   = s1Dx + s1Dvx;
    nxY   = s1Dy + s1Dvy;
    sqC   = s1Dx * s1Dx + s1Dy * s1Dy;
    nxtC  = nxX * nxX + nxY * nxY;
    ipSum = s1Dvx * s1Dx + s1Dvy * s1Dy;
    ipC   = ipSum >>> IP_SHIFT;
  end

  // Stage 2 holds the squares and inner product alongside dx/dy for stage 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2I     <= '0;
      s2J     <= '0;
      s2Dx    <= '0;
      s2Dy    <= '0;
      s2Sq    <= '0;
      s2Nxt   <= '0;
      s2Ip    <= '0;
    end else if (en) begin
      s2Valid <= s1Valid;
      s2I     <= s1I;
      s2J     <= s1J;
      s2Dx    <= s1Dx;
      s2Dy    <= s1Dy;
      s2Sq    <= sqC;
      s2Nxt   <= nxtC;
      s2Ip    <= ipC;
    end
  end

  // Projection terms and the approaching-within-diameter test.
  always_comb begin
    interXC = s2Dx * s2Ip;
    interYC = s2Dy * s2Ip;
    hitC    = (s2Sq <= RES_W'(DIAM_SQ)) && (s2Nxt < s2Sq);
  end

  // Stage 3 is the output register seen by the consumer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid  <= 1'b0;
      outI      <= '0;
      outJ      <= '0;
      sqDist    <= '0;
      nxtSqDist <= '0;
      interX    <= '0;
      interY    <= '0;
      hit       <= 1'b0;
    end else if (en) begin
      outValid  <= s2Valid;
      outI      <= s2I;
      outJ      <= s2J;
      sqDist    <= s2Sq;
      nxtSqDist <= s2Nxt;
      interX    <= interXC;
      interY    <= interYC;
      hit       <= hitC;
    end
  end

  assign pipeBusy = s1Valid | s2Valid;

endmodule

// File: rtl/ball_pair_collision_sweeper.sv
// Walks every unordered ball pair once per start request, feeding a shared
// arithmetic pipe and presenting results over a valid/ready stream.
module ball_pair_collision_sweeper
  import ball_coll_pkg::*;
#(
  parameter int          N_BALLS  = 4,
  parameter int          COORD_W  = 16,
  parameter int          RES_W    = 32,
  parameter int          IP_SHIFT = 2,
  parameter int unsigned DIAM_SQ  = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic signed [N_BALLS-1:0][COORD_W-1:0] ball_x,
  input  logic signed [N_BALLS-1:0][COORD_W-1:0] ball_y,
  input  logic signed [N_BALLS-1:0][COORD_W-1:0] ball_vx,
  input  logic signed [N_BALLS-1:0][COORD_W-1:0] ball_vy,
  input  logic [N_BALLS-1:0]                     ball_active,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [idx_w(N_BALLS)-1:0]              res_i,
  output logic [idx_w(N_BALLS)-1:0]              res_j,
  output logic [RES_W-1:0]                       sq_dist,
  output logic [RES_W-1:0]                       nxt_sq_dist,
  output logic signed [RES_W-1:0]                inter_x,
  output logic signed [RES_W-1:0]                inter_y,
  output logic                                   hit
);

  localparam int IDX_W = idx_w(N_BALLS);
  localparam int PAIRS = pair_cnt(N_BALLS);
  localparam int CNT_W = $clog2(PAIRS + 1);

  sweep_state_t state, nextState;
  logic [IDX_W-1:0] iQ, jQ, nextI, nextJ;
  logic [CNT_W-1:0] cntQ, nextCnt;
  logic doneQ, nextDone;
  logic enable, issueValid, pipeBusy;
  logic signed [COORD_W-1:0] xi, xj, yi, yj, vxi, vxj, vyi, vyj;

  assign enable = !res_valid || res_ready;
  assign busy   = (state != IDLE);
  assign done   = doneQ;

  // State, pair indices, issue count and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      iQ    <= '0;
      jQ    <= '0;
      cntQ  <= '0;
      doneQ <= 1'b0;
    end else begin
      state <= nextState;
      iQ    <= nextI;
      jQ    <= nextJ;
      cntQ  <= nextCnt;
      doneQ <= nextDone;
    end
  end

  // Sweep sequencing: j outer, i inner; a start coinciding with done is dropped.
  always_comb begin
    nextState  = state;
    nextI      = iQ;
    nextJ      = jQ;
    nextCnt    = cntQ;
    nextDone   = 1'b0;
    issueValid = 1'b0;
    case (state)
      IDLE: begin
        if (start && !doneQ) begin
          nextState = RUN;
          nextI     = '0;
          nextJ     = IDX_W'(1);
          nextCnt   = '0;
        end
      end
      RUN: begin
        if (enable) begin
          issueValid = ball_active[iQ] && ball_active[jQ];
          nextCnt    = cntQ + CNT_W'(1);
          if (cntQ == CNT_W'(PAIRS - 1)) begin
            nextState = DRAIN;
          end else if (iQ == jQ - IDX_W'(1)) begin
            nextI = '0;
            nextJ = jQ + IDX_W'(1);
          end else begin
            nextI = iQ + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (enable && !pipeBusy) begin
          nextState = IDLE;
          nextDone  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Select the current pair's operands from the ball register file.
  always_comb begin
    xi  = ball_x[iQ];
    xj  = ball_x[jQ];
    yi  = ball_y[iQ];
    yj  = ball_y[jQ];
    vxi = ball_vx[iQ];
    vxj = ball_vx[jQ];
    vyi = ball_vy[iQ];
    vyj = ball_vy[jQ];
  end

  ball_pair_calc_pipe #(
    .COORD_W (COORD_W),
    .RES_W   (RES_W),
    .IDX_W   (IDX_W),
    .IP_SHIFT(IP_SHIFT),
    .DIAM_SQ (DIAM_SQ)
  ) calcPipe (
    .clk      (clk),
    .reset    (reset),
    .en       (enable),
    .inValid  (issueValid),
    .inI      (iQ),
    .inJ      (jQ),
    .xi       (xi),
    .xj       (xj),
    .yi       (yi),
    .yj       (yj),
    .vxi      (vxi),
    .vxj      (vxj),
    .vyi      (vyi),
    .vyj      (vyj),
    .pipeBusy (pipeBusy),
    .outValid (res_valid),
    .outI     (res_i),
    .outJ     (res_j),
    .sqDist   (sq_dist),
    .nxtSqDist(nxt_sq_dist),
    .interX   (inter_x),
    .interY   (inter_y),
    .hit      (hit)
  );

endmodule

// File: tb/tb_ball_pair_collision_sweeper.sv
// Directed bench for the ball pair collision sweeper with hand-computed results.
module tb_ball_pair_collision_sweeper;
  import ball_coll_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic signed [3:0][15:0] ballX, ballY, ballVx, ballVy;
  logic [3:0] ballActive;
  logic busy, done, resValid, resReady;
  logic [1:0] resI, resJ;
  logic [31:0] sqDist, nxtSqDist;
  logic signed [31:0] interX, interY;
  logic hit;

  int checks = 0;
  int errors = 0;

  ball_pair_res_t tabA[6];
  ball_pair_res_t tabB[6];
  ball_pair_res_t expQ[$];

  ball_pair_collision_sweeper #(
    .N_BALLS (4),
    .COORD_W (16),
    .RES_W   (32),
    .IP_SHIFT(2),
    .DIAM_SQ (1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ball_x     (ballX),
    .ball_y     (ballY),
    .ball_vx    (ballVx),
    .ball_vy    (ballVy),
    .ball_active(ballActive),
    .busy       (busy),
    .done       (done),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_i      (resI),
    .res_j      (resJ),
    .sq_dist    (sqDist),
    .nxt_sq_dist(nxtSqDist),
    .inter_x    (interX),
    .inter_y    (interY),
    .hit        (hit)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ball_pair_res_t mkRes(input int i, input int j, input int unsigned sq,
                                           input int unsigned nxt, input int ix, input int iy,
                                           input bit h);
    ball_pair_res_t r;
    r.i           = 4'(i);
    r.j           = 4'(j);
    r.sq_dist     = sq;
    r.nxt_sq_dist = nxt;
    r.inter_x     = ix;
    r.inter_y     = iy;
    r.hit         = h;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input ball_pair_res_t e);
    checkOutput({tag, "_valid"}, 32'(resValid), 32'd1);
    checkOutput({tag, "_i"}, 32'(resI), 32'(e.i));
    checkOutput({tag, "_j"}, 32'(resJ), 32'(e.j));
    checkOutput({tag, "_sq"}, sqDist, e.sq_dist);
    checkOutput({tag, "_nxt"}, nxtSqDist, e.nxt_sq_dist);
    checkOutput({tag, "_ix"}, interX, e.inter_x);
    checkOutput({tag, "_iy"}, interY, e.inter_y);
    checkOutput({tag, "_hit"}, 32'(hit), 32'(e.hit));
  endtask

  // Pulse start for exactly one edge; returns sampling just after it.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Queue the expected results of one table for the pairs whose balls are both active.
  task automatic loadExp(input bit useB, input logic [3:0] act);
    ball_pair_res_t e;
    for (int k = 0; k < 6; k++) begin
      e = useB ? tabB[k] : tabA[k];
      if (act[e.i[1:0]] && act[e.j[1:0]]) expQ.push_back(e);
    end
  endtask

  task automatic waitValid(input int maxCycles);
    int cyc = 0;
    while (!resValid && cyc < maxCycles) begin
      tick();
      cyc++;
    end
    checkOutput("wait_valid", 32'(resValid), 32'd1);
  endtask

  // Consume results with ready high until done, comparing against the queue.
  task automatic collectSweep(input string tag, input int maxCycles);
    int cyc = 0;
    bit doneSeen = 1'b0;
    resReady = 1'b1;
    while (!doneSeen && cyc < maxCycles) begin
      if (resValid) begin
        if (expQ.size() > 0) checkResult(tag, expQ.pop_front());
        else checkOutput({tag, "_extra"}, 32'(resValid), 32'd0);
      end
      if (done) doneSeen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
    checkOutput({tag, "_left"}, 32'(expQ.size()), 32'd0);
    tick();
    checkOutput({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  task automatic setBallsA();
    ballX[0] = 16'sd0;  ballY[0] = 16'sd0;  ballVx[0] = 16'sd0;  ballVy[0] = 16'sd0;
    ballX[1] = 16'sd10; ballY[1] = 16'sd0;  ballVx[1] = -16'sd2; ballVy[1] = 16'sd0;
    ballX[2] = 16'sd0;  ballY[2] = 16'sd20; ballVx[2] = 16'sd0;  ballVy[2] = 16'sd0;
    ballX[3] = 16'sd30; ballY[3] = 16'sd40; ballVx[3] = 16'sd1;  ballVy[3] = -16'sd1;
  endtask

  task automatic setBallsB();
    ballX[0] = 16'sd0;     ballY[0] = 16'sd0;     ballVx[0] = 16'sd0;  ballVy[0] = 16'sd0;
    ballX[1] = 16'sd20000; ballY[1] = 16'sd15000; ballVx[1] = 16'sd0;  ballVy[1] = 16'sd0;
    ballX[2] = 16'sd0;     ballY[2] = 16'sd0;     ballVx[2] = 16'sd0;  ballVy[2] = 16'sd0;
    ballX[3] = 16'sd32;    ballY[3] = 16'sd0;     ballVx[3] = -16'sd1; ballVy[3] = 16'sd0;
  endtask

  initial begin
    tabA[0] = mkRes(0, 1, 100, 64, 50, 0, 1'b1);
    tabA[1] = mkRes(0, 2, 400, 400, 0, 0, 1'b0);
    tabA[2] = mkRes(1, 2, 500, 464, -50, 100, 1'b1);
    tabA[3] = mkRes(0, 3, 2500, 2482, 90, 120, 1'b0);
    tabA[4] = mkRes(1, 3, 2000, 2050, -100, -200, 1'b0);
    tabA[5] = mkRes(2, 3, 1300, 1322, -60, -40, 1'b0);

    tabB[0] = mkRes(0, 1, 625000000, 625000000, 0, 0, 1'b0);
    tabB[1] = mkRes(0, 2, 0, 0, 0, 0, 1'b0);
    tabB[2] = mkRes(1, 2, 625000000, 625000000, 0, 0, 1'b0);
    tabB[3] = mkRes(0, 3, 1024, 961, 256, 0, 1'b1);
    tabB[4] = mkRes(1, 3, 623721024, 623760961, 99680256, 74880000, 1'b0);
    tabB[5] = mkRes(2, 3, 1024, 961, 256, 0, 1'b1);

    reset      = 1'b1;
    start      = 1'b0;
    resReady   = 1'b1;
    ballActive = 4'b1111;
    setBallsA();

    $display("[TB] reset state");
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(resValid), 32'd0);
    checkOutput("rst_sq", sqDist, 32'd0);
    checkOutput("rst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("[TB] full sweep with exact timing");
    loadExp(1'b0, 4'b1111);
    applyStimulus();
    checkOutput("busy_e0", 32'(busy), 32'd1);
    checkOutput("novalid_e0", 32'(resValid), 32'd0);
    tick();
    checkOutput("novalid_e1", 32'(resValid), 32'd0);
    tick();
    checkOutput("novalid_e2", 32'(resValid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkResult("sweep", expQ.pop_front());
      start = (k == 1);
    end
    start = 1'b0;
    tick();
    checkOutput("done_e9", 32'(done), 32'd1);
    checkOutput("busy_e9", 32'(busy), 32'd0);
    checkOutput("novalid_e9", 32'(resValid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("done_e10", 32'(done), 32'd0);
    checkOutput("start_on_done_ignored", 32'(busy), 32'd0);
    tick();
    checkOutput("still_idle", 32'(busy), 32'd0);

    $display("[TB] backpressure");
    loadExp(1'b0, 4'b1111);
    resReady = 1'b0;
    applyStimulus();
    waitValid(10);
    for (int k = 0; k < 5; k++) begin
      checkResult("stall", expQ[0]);
      tick();
    end
    collectSweep("bp", 60);

    $display("[TB] masked ball 2");
    ballActive = 4'b1011;
    loadExp(1'b0, 4'b1011);
    applyStimulus();
    collectSweep("mask", 40);

    $display("[TB] all pairs masked");
    ballActive = 4'b0001;
    applyStimulus();
    collectSweep("allmask", 40);
    ballActive = 4'b1111;

    $display("[TB] large values and threshold boundary");
    setBallsB();
    loadExp(1'b1, 4'b1111);
    applyStimulus();
    collectSweep("thresh", 40);

    $display("[TB] reset mid-sweep");
    setBallsA();
    loadExp(1'b0, 4'b1111);
    applyStimulus();
    tick();
    tick();
    tick();
    checkResult("prerst", expQ.pop_front());
    tick();
    checkResult("prerst", expQ.pop_front());
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_valid", 32'(resValid), 32'd0);
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("postrst_done", 32'(done), 32'd0);
    checkOutput("postrst_busy", 32'(busy), 32'd0);
    expQ.delete();
    loadExp(1'b0, 4'b1111);
    applyStimulus();
    collectSweep("rerun", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
